osd_wr_arbiter: RTL and testbench

OSD_WR_ARBITER -- requirements
Module: osd_wr_arbiter

---
 rtl/osd_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_osd_wr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/osd_wr_arbiter.sv
// osd_wr_arbiter: merges SPI, clear-screen and core character writes onto one
// registered tile-map write port. Fixed priority: SPI > clear sequencer > core.
// Build option: define OSD_ARB_CLEAR_EN to include the clear-screen sequencer.
// Without it, clr_req is ignored and clr_busy is tied low.
module osd_wr_arbiter #(
  parameter int          c_chars_x      = 64,
  parameter int          c_chars_y      = 24,
  parameter logic [7:0]  c_addr_display = 8'hFD,
  parameter logic [7:0]  c_clear_char   = 8'h20
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        spi_wr,
  input  logic [31:0] spi_addr,
  input  logic [7:0]  spi_data,
  input  logic        core_req,
  input  logic [11:0] core_addr,
  input  logic [7:0]  core_data,
  input  logic        core_inv,
  output logic        core_ack,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic        o_wr,
  output logic [31:0] o_addr,
  output logic [7:0]  o_data
);

  localparam int          c_num_chars = c_chars_x * c_chars_y;
  localparam logic [11:0] c_last_idx  = 12'(c_num_chars - 1);

  logic        o_wr_d, o_wr_q;
  logic [31:0] o_addr_d, o_addr_q;
  logic [7:0]  o_data_d, o_data_q;
  logic        clr_grant;
  logic [11:0] clr_idx;
  logic        core_grant;

`ifdef OSD_ARB_CLEAR_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      state_d, state_q;
  logic [11:0] idx_d, idx_q;

  // Clear sequencer: walks the tile index, yielding every cycle SPI writes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_req) begin
          // Restart from the top; the current index is rewritten anyway.
          idx_d = '0;
        end else if (!spi_wr) begin
          clr_grant = 1'b1;
          if (idx_q == c_last_idx) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 12'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign clr_idx    = idx_q;
  assign clr_busy   = (state_q == ST_CLEAR);
  assign core_grant = core_req & ~spi_wr & ~clr_busy & ~reset;
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_grant      = 1'b0;
  assign clr_idx        = '0;
  assign clr_busy       = 1'b0;
  assign core_grant     = core_req & ~spi_wr & ~reset;
`endif

  // The core is acknowledged in the same cycle it wins arbitration.
  assign core_ack = core_grant;

  // Priority mux feeding the output register; address/data hold when idle.
  always_comb begin
    o_wr_d   = 1'b0;
    o_addr_d = o_addr_q;
    o_data_d = o_data_q;
    if (spi_wr) begin
      o_wr_d   = 1'b1;
      o_addr_d = spi_addr;
      o_data_d = spi_data;
    end else if (clr_grant) begin
      o_wr_d   = 1'b1;
      o_addr_d = {c_addr_display, 7'b0, 1'b0, 4'b0, clr_idx};
      o_data_d = c_clear_char;
    end else if (core_grant) begin
      o_wr_d   = 1'b1;
      o_addr_d = {c_addr_display, 7'b0, core_inv, 4'b0, core_addr};
      o_data_d = core_data;
    end
  end

  // Output register: one-cycle latency from grant to write strobe.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      o_wr_q   <= 1'b0;
      o_addr_q <= '0;
      o_data_q <= '0;
    end else begin
      o_wr_q   <= o_wr_d;
      o_addr_q <= o_addr_d;
      o_data_q <= o_data_d;
    end
  end

  assign o_wr   = o_wr_q;
  assign o_addr = o_addr_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Self-checking bench for osd_wr_arbiter. Expected writes are queued when a
// grant is expected and compared when the write strobe appears. Clear-sequencer
// scenarios run when OSD_ARB_CLEAR_EN is defined.
module tb_osd_wr_arbiter;

  logic        clk_pixel;
  logic        reset;
  logic        spi_wr;
  logic [31:0] spi_addr;
  logic [7:0]  spi_data;
  logic        core_req;
  logic [11:0] core_addr;
  logic [7:0]  core_data;
  logic        core_inv;
  logic        core_ack;
  logic        clr_req;
  logic        clr_busy;
  logic        o_wr;
  logic [31:0] o_addr;
  logic [7:0]  o_data;

  int n_checks;
  int n_errors;
  logic mon_en;
  logic [39:0] exp_q[$];

  osd_wr_arbiter dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .spi_wr    (spi_wr),
    .spi_addr  (spi_addr),
    .spi_data  (spi_data),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_data (core_data),
    .core_inv  (core_inv),
    .core_ack  (core_ack),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .o_wr      (o_wr),
    .o_addr    (o_addr),
    .o_data    (o_data)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: every write strobe must match the oldest queued expectation,
  // and every queued expectation must appear in the cycle after its grant.
  always @(posedge clk_pixel) begin
    #2;
    if (mon_en) begin
      if (o_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", {o_addr, o_data}, 40'h0);
        end else begin
          chk("wr_addr_data", {o_addr, o_data}, exp_q.pop_front());
        end
        $display("write addr=%h data=%h t=%0t", o_addr, o_data, $time);
      end else if (exp_q.size() != 0) begin
        chk("missing_wr", {39'h0, o_wr}, 40'h1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; in_clear says whether the sequencer is active
  // this cycle, clr_idx (>= 0) is the clear index expected to be granted.
  task automatic cyc(input logic sw, input logic [31:0] sa, input logic [7:0] sd,
                     input logic cr, input logic [11:0] ca, input logic [7:0] cd,
                     input logic ci, input logic clr, input logic rst,
                     input logic in_clear, input int clr_idx, output logic acked);
    logic exp_ack;
    spi_wr    = sw;
    spi_addr  = sa;
    spi_data  = sd;
    core_req  = cr;
    core_addr = ca;
    core_data = cd;
    core_inv  = ci;
    clr_req   = clr;
    reset     = rst;
    @(negedge clk_pixel);
    exp_ack = cr & ~sw & ~rst & ~in_clear;
    chk("core_ack", {39'h0, core_ack}, {39'h0, exp_ack});
    chk("clr_busy", {39'h0, clr_busy}, {39'h0, in_clear});
    if (!rst) begin
      if (sw) exp_q.push_back({sa, sd});
      else if (clr_idx >= 0) exp_q.push_back({8'hFD, 12'h000, 12'(clr_idx), 8'h20});
      else if (exp_ack) exp_q.push_back({8'hFD, 7'b0, ci, 4'b0, ca, cd});
    end
    acked = exp_ack;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle(input logic in_clear);
    logic a;
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0, in_clear, -1, a);
  endtask

  initial begin
    logic a;
    logic pend;
    logic [11:0] pa;
    logic [7:0] pd;
    logic pi;
    int idx;
    logic injected;

    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    reset = 1'b1; spi_wr = 1'b0; spi_addr = '0; spi_data = '0;
    core_req = 1'b0; core_addr = '0; core_data = '0; core_inv = 1'b0; clr_req = 1'b0;
    @(posedge clk_pixel);
    #1;
    mon_en = 1'b1;

    // Reset with every request active: nothing granted, outputs cleared.
    cyc(1'b1, 32'hDEADBEEF, 8'h55, 1'b1, 12'h001, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, -1, a);
    cyc(1'b1, 32'hDEADBEEF, 8'h55, 1'b1, 12'h001, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, -1, a);
    chk("rst_o_wr", {39'h0, o_wr}, 40'h0);
    chk("rst_o_addr", {8'h0, o_addr}, 40'h0);
    chk("rst_o_data", {32'h0, o_data}, 40'h0);
    chk("rst_clr_busy", {39'h0, clr_busy}, 40'h0);
    idle(1'b0);

    // SPI pass-through.
    cyc(1'b1, 32'hFD000005, 8'h41, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1, a);
    // Core write with inverse bit.
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'h010, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0, -1, a);
    idle(1'b0);
    // SPI and core collide: SPI first, core acknowledged the cycle after.
    cyc(1'b1, 32'h01020304, 8'hA5, 1'b1, 12'h123, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, -1, a);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'h123, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, -1, a);
    idle(1'b0);
    // Out-of-window core address forwarded untouched.
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'hFFF, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, -1, a);
    idle(1'b0);

    // Randomised SPI traffic against a core that holds its request until acked.
    pend = 1'b0; pa = '0; pd = '0; pi = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!pend && ($urandom_range(1) == 1)) begin
        pend = 1'b1;
        pa = 12'($urandom);
        pd = 8'($urandom);
        pi = 1'($urandom);
      end
      cyc(($urandom_range(2) == 0), $urandom, 8'($urandom), pend, pa, pd, pi,
          1'b0, 1'b0, 1'b0, -1, a);
      if (a) pend = 1'b0;
    end
    if (pend) cyc(1'b0, 32'h0, 8'h0, 1'b1, pa, pd, pi, 1'b0, 1'b0, 1'b0, -1, a);
    idle(1'b0);

`ifdef OSD_ARB_CLEAR_EN
    // Full clear with one SPI write injected at index 100 and the core waiting.
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, a);
    idx = 0;
    injected = 1'b0;
    while (idx < 1536) begin
      if (idx == 100 && !injected) begin
        injected = 1'b1;
        cyc(1'b1, 32'h12345678, 8'h99, 1'b1, 12'h055, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1, a);
      end else begin
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'h055, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, idx, a);
        idx++;
      end
    end
    // Sequencer finished: core is served immediately.
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'h055, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, -1, a);
    idle(1'b0);

    // Clear interrupted by reset at index 500.
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, a);
    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, 32'h0, 8'h0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, i, a);
    end
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1, -1, a);
    chk("abort_o_wr", {39'h0, o_wr}, 40'h0);
    for (int i = 0; i < 5; i++) idle(1'b0);
`else
    // Without the sequencer, clr_req is inert and the core is still served.
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 12'h200, 8'h61, 1'b0, 1'b1, 1'b0, 1'b0, -1, a);
    idle(1'b0);
    idle(1'b0);
`endif

    idle(1'b0);
    chk("queue_drained", 40'(exp_q.size()), 40'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
